// File: rtl/cache_miss_controller.sv
// Miss/hit sequencer for a 4-way set-associative cache.
// Owns the per-set tree PLRU state; the array owns tags/data/valid/dirty.
module cache_miss_controller #(
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WAYS            = 4,
  localparam int INDEX_WIDTH    = $clog2(CACHE_LINES),
  localparam int OFFSET_WIDTH   = $clog2(LINE_SIZE_BYTES),
  localparam int TAG_BITS       = ADDRESS_WIDTH - INDEX_WIDTH
                                  - OFFSET_WIDTH,
  localparam int LINE_WIDTH     = ADDRESS_WIDTH - OFFSET_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic                     i_req_we,
  output logic                     o_resp_valid,
  output logic                     o_resp_hit,
  output logic                     o_lookup_en,
  output logic [INDEX_WIDTH-1:0]   o_lookup_index,
  input  logic [WAYS-1:0]          i_way_hit,
  input  logic [WAYS-1:0]          i_way_valid,
  input  logic [WAYS-1:0]          i_way_dirty,
  input  logic [TAG_BITS-1:0]      i_victim_tag,
  output logic [WAYS-1:0]          o_way_sel,
  output logic                     o_dirty_set,
  output logic                     o_fill_en,
  output logic                     o_mem_req_valid,
  input  logic                     i_mem_req_ready,
  output logic                     o_mem_we,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  input  logic                     i_mem_resp_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_WAIT,
    S_RF_REQ,
    S_RF_WAIT,
    S_FILL,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  we_q, we_d;
  logic                  hit_q, hit_d;
  logic [WAYS-1:0]       victim_q, victim_d;
  logic [2:0]            plru_q [CACHE_LINES];
  logic [2:0]            plru_d [CACHE_LINES];

  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_BITS-1:0]    tag;
  logic [2:0]             plru_cur;
  logic [WAYS-1:0]        hit_oh;
  logic [WAYS-1:0]        inv_oh;
  logic [WAYS-1:0]        plru_vic;
  logic [WAYS-1:0]        miss_vic;
  logic                   vic_dirty;
  logic                   unused_offset;

  assign unused_offset = ^i_req_addr[OFFSET_WIDTH-1:0];

  function automatic logic [WAYS-1:0] lowest_oh(
    input logic [WAYS-1:0] v
  );
    logic [WAYS-1:0] r;
    r = '0;
    if (v[0])      r[0] = 1'b1;
    else if (v[1]) r[1] = 1'b1;
    else if (v[2]) r[2] = 1'b1;
    else if (v[3]) r[3] = 1'b1;
    return r;
  endfunction

  // Point the tree away from the way just touched.
  function automatic logic [2:0] plru_touch(
    input logic [2:0]      p,
    input logic [WAYS-1:0] w
  );
    logic [2:0] n;
    n = p;
    if (w[0] | w[1]) begin
      n[0] = 1'b1;
      n[1] = w[0];
    end else begin
      n[0] = 1'b0;
      n[2] = w[2];
    end
    return n;
  endfunction

  assign index    = line_q[INDEX_WIDTH-1:0];
  assign tag      = line_q[LINE_WIDTH-1:INDEX_WIDTH];
  assign plru_cur = plru_q[index];
  assign hit_oh   = lowest_oh(i_way_hit);
  assign inv_oh   = lowest_oh(~i_way_valid);

  always_comb begin
    plru_vic = '0;
    if (!plru_cur[0]) begin
      if (plru_cur[1]) plru_vic[1] = 1'b1;
      else             plru_vic[0] = 1'b1;
    end else begin
      if (plru_cur[2]) plru_vic[3] = 1'b1;
      else             plru_vic[2] = 1'b1;
    end
  end

  assign miss_vic  = (&i_way_valid) ? plru_vic : inv_oh;
  assign vic_dirty = |(miss_vic & i_way_valid & i_way_dirty);

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    we_d            = we_q;
    hit_d           = hit_q;
    victim_d        = victim_q;
    plru_d          = plru_q;
    o_req_ready     = 1'b0;
    o_resp_valid    = 1'b0;
    o_resp_hit      = 1'b0;
    o_lookup_en     = 1'b0;
    o_lookup_index  = index;
    o_way_sel       = '0;
    o_dirty_set     = 1'b0;
    o_fill_en       = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_addr      = '0;
    unique case (state_q)
      S_IDLE: begin
        o_req_ready    = 1'b1;
        o_lookup_index = '0;
        if (i_req_valid) begin
          line_d  = i_req_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
          we_d    = i_req_we;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        o_lookup_en = 1'b1;
        if (|i_way_hit) begin
          o_way_sel     = hit_oh;
          o_dirty_set   = we_q;
          plru_d[index] = plru_touch(plru_cur, hit_oh);
          hit_d         = 1'b1;
          state_d       = S_RESP;
        end else begin
          victim_d = miss_vic;
          hit_d    = 1'b0;
          state_d  = vic_dirty ? S_WB_REQ : S_RF_REQ;
        end
      end
      S_WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_we        = 1'b1;
        o_way_sel       = victim_q;
        o_mem_addr      = {i_victim_tag, index,
                           {OFFSET_WIDTH{1'b0}}};
        if (i_mem_req_ready) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (i_mem_resp_valid) state_d = S_RF_REQ;
      end
      S_RF_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = {tag, index, {OFFSET_WIDTH{1'b0}}};
        if (i_mem_req_ready) state_d = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        if (i_mem_resp_valid) state_d = S_FILL;
      end
      S_FILL: begin
        o_fill_en     = 1'b1;
        o_way_sel     = victim_q;
        o_dirty_set   = we_q;
        plru_d[index] = plru_touch(plru_cur, victim_q);
        state_d       = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_hit   = hit_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs stay quiet while reset is asserted.
    if (rst) begin
      o_req_ready     = 1'b0;
      o_resp_valid    = 1'b0;
      o_resp_hit      = 1'b0;
      o_lookup_en     = 1'b0;
      o_lookup_index  = '0;
      o_way_sel       = '0;
      o_dirty_set     = 1'b0;
      o_fill_en       = 1'b0;
      o_mem_req_valid = 1'b0;
      o_mem_we        = 1'b0;
      o_mem_addr      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      victim_q <= '0;
      for (int i = 0; i < CACHE_LINES; i++) begin
        plru_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      we_q     <= we_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
      plru_q   <= plru_d;
    end
  end

  a_hit_onehot: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == S_LOOKUP) |-> $onehot0(i_way_hit)
  );

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller: transaction table
// plus hand sequences for stalls and mid-miss reset.
module tb_cache_miss_controller;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_we;
  logic        o_resp_valid;
  logic        o_resp_hit;
  logic        o_lookup_en;
  logic [7:0]  o_lookup_index;
  logic [3:0]  i_way_hit;
  logic [3:0]  i_way_valid;
  logic [3:0]  i_way_dirty;
  logic [17:0] i_victim_tag;
  logic [3:0]  o_way_sel;
  logic        o_dirty_set;
  logic        o_fill_en;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic        i_mem_resp_valid;

  int n_cmp = 0;
  int n_bad = 0;

  cache_miss_controller dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_addr       (i_req_addr),
    .i_req_we         (i_req_we),
    .o_resp_valid     (o_resp_valid),
    .o_resp_hit       (o_resp_hit),
    .o_lookup_en      (o_lookup_en),
    .o_lookup_index   (o_lookup_index),
    .i_way_hit        (i_way_hit),
    .i_way_valid      (i_way_valid),
    .i_way_dirty      (i_way_dirty),
    .i_victim_tag     (i_victim_tag),
    .o_way_sel        (o_way_sel),
    .o_dirty_set      (o_dirty_set),
    .o_fill_en        (o_fill_en),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_we         (o_mem_we),
    .o_mem_addr       (o_mem_addr),
    .i_mem_resp_valid (i_mem_resp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  hit;
    logic [3:0]  valid;
    logic [3:0]  dirty;
    logic [17:0] vtag;
    logic        e_hit;
    int          e_lat;
    logic [3:0]  e_sel;
    logic [31:0] e_wb;
    logic [31:0] e_rf;
    logic [2:0]  e_plru;
  } vec_t;

  typedef struct {
    logic        hit;
    int          lat;
    logic [3:0]  sel_lk;
    logic [3:0]  sel_fill;
    logic        dset_lk;
    logic        dset_fill;
    logic        wb_seen;
    logic        rf_seen;
    logic [31:0] wb_addr;
    logic [31:0] rf_addr;
  } res_t;

  vec_t vt [14];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic we,
    input logic [3:0] hit, input logic [3:0] valid,
    input logic [3:0] dirty, input logic [17:0] vtag,
    input logic e_hit, input int e_lat,
    input logic [3:0] e_sel, input logic [31:0] e_wb,
    input logic [31:0] e_rf, input logic [2:0] e_plru);
    vec_t v;
    v.addr = addr;   v.we = we;       v.hit = hit;
    v.valid = valid; v.dirty = dirty; v.vtag = vtag;
    v.e_hit = e_hit; v.e_lat = e_lat; v.e_sel = e_sel;
    v.e_wb = e_wb;   v.e_rf = e_rf;   v.e_plru = e_plru;
    return v;
  endfunction

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!o_req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!o_req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s accept timeout: got 0 want 1", nm);
    end
  endtask

  // Zero-wait memory: ack one cycle after each accepted request.
  task automatic run_txn(input vec_t v, output res_t r);
    logic pend;
    r.hit = 1'b0;      r.lat = -1;
    r.sel_lk = '0;     r.sel_fill = '0;
    r.dset_lk = 1'b0;  r.dset_fill = 1'b0;
    r.wb_seen = 1'b0;  r.rf_seen = 1'b0;
    r.wb_addr = '0;    r.rf_addr = '0;
    i_way_hit    = v.hit;
    i_way_valid  = v.valid;
    i_way_dirty  = v.dirty;
    i_victim_tag = v.vtag;
    i_req_addr   = v.addr;
    i_req_we     = v.we;
    i_req_valid  = 1'b1;
    wait_ready("txn");
    pend = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      i_req_valid      = 1'b0;
      i_mem_resp_valid = pend;
      pend             = 1'b0;
      if (o_lookup_en) begin
        r.sel_lk  = o_way_sel;
        r.dset_lk = o_dirty_set;
      end
      if (o_mem_req_valid && i_mem_req_ready) begin
        pend = 1'b1;
        if (o_mem_we) begin
          r.wb_seen = 1'b1;
          r.wb_addr = o_mem_addr;
        end else begin
          r.rf_seen = 1'b1;
          r.rf_addr = o_mem_addr;
        end
      end
      if (o_fill_en) begin
        r.sel_fill  = o_way_sel;
        r.dset_fill = o_dirty_set;
      end
      if (o_resp_valid) begin
        r.lat = c;
        r.hit = o_resp_hit;
        break;
      end
    end
    i_mem_resp_valid = 1'b0;
  endtask

  initial begin
    res_t r;
    string p;
    logic [3:0] sel_act;
    logic dset_act;
    logic [7:0] idx;

    vt[0]  = mk(32'h00001040, 0, 4'b0100, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b0100, 32'h0, 32'h0, 3'b100);
    vt[1]  = mk(32'h00001040, 0, 4'b0000, 4'b0000, 4'b0000, 18'h0,
                0, 5, 4'b0001, 32'h0, 32'h00001040, 3'b111);
    vt[2]  = mk(32'h00001045, 1, 4'b0001, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b0001, 32'h0, 32'h0, 3'b111);
    vt[3]  = mk(32'h00001040, 0, 4'b0010, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b0010, 32'h0, 32'h0, 3'b101);
    vt[4]  = mk(32'h00001040, 1, 4'b0100, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b0100, 32'h0, 32'h0, 3'b100);
    vt[5]  = mk(32'h00001040, 0, 4'b1000, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b1000, 32'h0, 32'h0, 3'b000);
    vt[6]  = mk(32'h00001040, 0, 4'b0000, 4'b1111, 4'b0000, 18'h0,
                0, 5, 4'b0001, 32'h0, 32'h00001040, 3'b011);
    vt[7]  = mk(32'h00001040, 0, 4'b0010, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b0010, 32'h0, 32'h0, 3'b001);
    vt[8]  = mk(32'h00001040, 0, 4'b1000, 4'b1111, 4'b0000, 18'h0,
                1, 2, 4'b1000, 32'h0, 32'h0, 3'b000);
    vt[9]  = mk(32'h00001040, 1, 4'b0000, 4'b1111, 4'b0001, 18'h01234,
                0, 7, 4'b0001, 32'h048D1040, 32'h00001040, 3'b011);
    vt[10] = mk(32'h00ABC0BF, 0, 4'b0000, 4'b1101, 4'b0010, 18'h0,
                0, 5, 4'b0010, 32'h0, 32'h00ABC080, 3'b001);
    vt[11] = mk(32'h00ABC0BF, 0, 4'b0000, 4'b1111, 4'b0000, 18'h0,
                0, 5, 4'b0100, 32'h0, 32'h00ABC080, 3'b100);
    vt[12] = mk(32'h00ABC0BF, 1, 4'b0000, 4'b1111, 4'b1111, 18'h3FFFF,
                0, 7, 4'b0001, 32'hFFFFC080, 32'h00ABC080, 3'b111);
    vt[13] = mk(32'h00ABC0BF, 0, 4'b0000, 4'b1111, 4'b0100, 18'h3FFFF,
                0, 5, 4'b1000, 32'h0, 32'h00ABC080, 3'b010);

    rst = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr = 32'h00001040;
    i_req_we = 1'b0;
    i_way_hit = '0;
    i_way_valid = '0;
    i_way_dirty = '0;
    i_victim_tag = '0;
    i_mem_req_ready = 1'b1;
    i_mem_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ready", o_req_ready, 0);
    check("rst resp_valid", o_resp_valid, 0);
    check("rst lookup_en", o_lookup_en, 0);
    check("rst mem_req_valid", o_mem_req_valid, 0);
    check("rst fill_en", o_fill_en, 0);
    i_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", o_req_ready, 1);
    check("post-rst plru41", dut.plru_q[8'h41], 0);

    for (int i = 0; i < 14; i++) begin
      run_txn(vt[i], r);
      p = $sformatf("row%0d", i);
      sel_act  = vt[i].e_hit ? r.sel_lk : r.sel_fill;
      dset_act = vt[i].e_hit ? r.dset_lk : r.dset_fill;
      idx = vt[i].addr[13:6];
      check({p, " lat"}, r.lat, vt[i].e_lat);
      check({p, " resp_hit"}, r.hit, vt[i].e_hit);
      check({p, " way_sel"}, sel_act, vt[i].e_sel);
      check({p, " dirty_set"}, dset_act, vt[i].we);
      check({p, " wb_seen"}, r.wb_seen, vt[i].e_wb != 0);
      check({p, " wb_addr"}, r.wb_addr, vt[i].e_wb);
      check({p, " rf_seen"}, r.rf_seen, vt[i].e_rf != 0);
      check({p, " rf_addr"}, r.rf_addr, vt[i].e_rf);
      check({p, " plru"}, dut.plru_q[idx], vt[i].e_plru);
    end

    // Refill request stalled five cycles; a second request waits.
    @(negedge clk);
    i_mem_req_ready = 1'b0;
    i_way_hit = '0;
    i_way_valid = '0;
    i_way_dirty = '0;
    i_req_addr = 32'h00002200;
    i_req_we = 1'b0;
    i_req_valid = 1'b1;
    wait_ready("stall");
    @(negedge clk);
    i_req_addr = 32'h00003300;
    check("stall lookup_en", o_lookup_en, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      p = $sformatf("stall%0d", k);
      check({p, " mem_req_valid"}, o_mem_req_valid, 1);
      check({p, " mem_addr"}, o_mem_addr, 32'h00002200);
      check({p, " mem_we"}, o_mem_we, 0);
      check({p, " req_ready"}, o_req_ready, 0);
    end
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    check("stall rf_wait mem_req", o_mem_req_valid, 0);
    i_mem_resp_valid = 1'b1;
    @(negedge clk);
    i_mem_resp_valid = 1'b0;
    check("stall fill_en", o_fill_en, 1);
    check("stall fill sel", o_way_sel, 4'b0001);
    check("stall fill req_ready", o_req_ready, 0);
    @(negedge clk);
    check("stall resp_valid", o_resp_valid, 1);
    check("stall resp_hit", o_resp_hit, 0);
    check("stall resp req_ready", o_req_ready, 0);
    @(negedge clk);
    check("stall idle req_ready", o_req_ready, 1);
    i_way_hit = 4'b0001;
    i_way_valid = 4'b1111;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("2nd lookup_en", o_lookup_en, 1);
    check("2nd lookup_index", o_lookup_index, 8'hCC);
    @(negedge clk);
    check("2nd resp_valid", o_resp_valid, 1);
    check("2nd resp_hit", o_resp_hit, 1);

    // Reset while waiting for refill data.
    @(negedge clk);
    i_way_hit = '0;
    i_way_valid = '0;
    i_req_addr = 32'h00004400;
    i_req_valid = 1'b1;
    wait_ready("rst-mid");
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    check("rstmid rf_req", o_mem_req_valid, 1);
    check("rstmid rf_addr", o_mem_addr, 32'h00004400);
    @(negedge clk);
    check("rstmid rf_wait", o_mem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid mem_req_valid", o_mem_req_valid, 0);
    check("rstmid resp_valid", o_resp_valid, 0);
    check("rstmid req_ready", o_req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid rel req_ready", o_req_ready, 1);
    check("rstmid plru41", dut.plru_q[8'h41], 0);
    check("rstmid plru02", dut.plru_q[8'h02], 0);
    check("rstmid plru88", dut.plru_q[8'h88], 0);
    for (int k = 0; k < 3; k++) begin
      i_mem_resp_valid = 1'b1;
      @(negedge clk);
      p = $sformatf("stray%0d", k);
      check({p, " resp_valid"}, o_resp_valid, 0);
      check({p, " req_ready"}, o_req_ready, 1);
      check({p, " fill_en"}, o_fill_en, 0);
    end
    i_mem_resp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
